// File: rtl/dual_port_ram_pkg.sv
// ----------------------------------------------------------------------------
// dual_port_ram_pkg
// Shared types and limits for dual_port_ram_pipelined.
//   dpr_req_t       : one sampled port request (en, we, addr, din, be), sized to
//                     the largest supported WIDTH/ADDR_WIDTH; unused upper bits
//                     are always zero.
//   DPR_*_LATENCY   : legal range of every read/write latency parameter.
//   dpr_in_range    : address-versus-DEPTH bounds test.
// ----------------------------------------------------------------------------
package dual_port_ram_pkg;

    localparam int unsigned DPR_MIN_LATENCY    = 1;
    localparam int unsigned DPR_MAX_LATENCY    = 16;
    localparam int unsigned DPR_MAX_WIDTH      = 256;
    localparam int unsigned DPR_MAX_ADDR_WIDTH = 16;

    typedef struct packed {
        logic                            en;
        logic                            we;
        logic [DPR_MAX_ADDR_WIDTH-1:0]   addr;
        logic [DPR_MAX_WIDTH-1:0]        din;
        logic [DPR_MAX_WIDTH/8-1:0]      be;
    } dpr_req_t;

    function automatic logic dpr_in_range(input logic [DPR_MAX_ADDR_WIDTH-1:0] addr,
                                          input int unsigned depth);
        return 32'(addr) < depth;
    endfunction

endpackage

// File: rtl/dpr_delay_line.sv
// ----------------------------------------------------------------------------
// dpr_delay_line
// Fixed-length shift register carrying a request of type T for DELAY cycles.
// The input is captured on the first edge, so q_o shows the request during
// the cycle that ends with edge DELAY. Synchronous active-high reset clears
// every stage, which drops all in-flight requests.
//   clk_i : clock
//   rst_i : synchronous reset, active high
//   d_i   : request entering the line
//   q_o   : request leaving the line
// ----------------------------------------------------------------------------
module dpr_delay_line
    import dual_port_ram_pkg::*;
#(
    parameter int unsigned DELAY = 1,
    parameter type         T     = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  T     d_i,
    output T     q_o
);

    if (DELAY < DPR_MIN_LATENCY || DELAY > DPR_MAX_LATENCY) begin : g_bad_delay
        $error("dpr_delay_line: DELAY out of range");
    end

    T stage_q [DELAY];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DELAY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < DELAY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DELAY-1];

endmodule

// File: rtl/dual_port_ram_pipelined.sv
// ----------------------------------------------------------------------------
// dual_port_ram_pipelined
// Two-port RAM with independent, fixed read and write latencies per port.
// Requests are sampled when i_en_p=1 and travel down a delay line; writes
// commit (byte-masked) WRITE_LATENCY_p edges later, reads register data
// READ_LATENCY_p edges later with a one-cycle o_rvalid_p pulse. Reads see the
// array as it was before same-edge commits. On a same-address commit collision
// port A wins every byte it enables. Addresses >= DEPTH drop writes and read 0.
// The array itself is never reset.
// Ports:
//   i_clk, i_rst                     : clock, synchronous active-high reset
//   i_en_p, i_we_p, i_addr_p,
//   i_din_p, i_be_p  (p = a, b)      : request inputs
//   o_dout_p, o_rvalid_p             : read data and valid pulse
//   o_collision                      : only with DPR_COLLISION_EN defined;
//                                      pulses one edge after an A/B same-address
//                                      commit with overlapping byte enables
// ----------------------------------------------------------------------------
module dual_port_ram_pipelined
    import dual_port_ram_pkg::*;
#(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned ADDR_WIDTH      = 4,
    parameter int unsigned DEPTH           = 2**ADDR_WIDTH,
    parameter int unsigned WRITE_LATENCY_A = 4,
    parameter int unsigned WRITE_LATENCY_B = 4,
    parameter int unsigned READ_LATENCY_A  = 5,
    parameter int unsigned READ_LATENCY_B  = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en_a,
    input  logic                  i_we_a,
    input  logic [ADDR_WIDTH-1:0] i_addr_a,
    input  logic [WIDTH-1:0]      i_din_a,
    input  logic [WIDTH/8-1:0]    i_be_a,
    input  logic                  i_en_b,
    input  logic                  i_we_b,
    input  logic [ADDR_WIDTH-1:0] i_addr_b,
    input  logic [WIDTH-1:0]      i_din_b,
    input  logic [WIDTH/8-1:0]    i_be_b,
    output logic [WIDTH-1:0]      o_dout_a,
    output logic                  o_rvalid_a,
    output logic [WIDTH-1:0]      o_dout_b,
    output logic                  o_rvalid_b
`ifdef DPR_COLLISION_EN
   ,output logic                  o_collision
`endif
);

    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (WIDTH == 0 || (WIDTH % 8) != 0 || WIDTH > DPR_MAX_WIDTH) begin : g_bad_width
        $error("dual_port_ram_pipelined: WIDTH must be a non-zero multiple of 8");
    end
    if (ADDR_WIDTH == 0 || ADDR_WIDTH > DPR_MAX_ADDR_WIDTH ||
        DEPTH == 0 || DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
        $error("dual_port_ram_pipelined: bad ADDR_WIDTH/DEPTH");
    end

    function automatic dpr_req_t make_req(input logic                  en,
                                          input logic                  we,
                                          input logic [ADDR_WIDTH-1:0] addr,
                                          input logic [WIDTH-1:0]      din,
                                          input logic [NBYTES-1:0]     be);
        dpr_req_t r;
        r                   = '0;
        r.en                = en;
        r.we                = we;
        r.addr[ADDR_WIDTH-1:0] = addr;
        r.din[WIDTH-1:0]    = din;
        r.be[NBYTES-1:0]    = be;
        return r;
    endfunction

    dpr_req_t wr_a_d, rd_a_d, wr_b_d, rd_b_d;
    dpr_req_t wr_a_q, rd_a_q, wr_b_q, rd_b_q;

    // Requests seen while reset is high never enter the pipeline.
    always_comb begin
        wr_a_d = make_req(i_en_a &  i_we_a & ~i_rst, 1'b1, i_addr_a, i_din_a, i_be_a);
        rd_a_d = make_req(i_en_a & ~i_we_a & ~i_rst, 1'b0, i_addr_a, '0, '0);
        wr_b_d = make_req(i_en_b &  i_we_b & ~i_rst, 1'b1, i_addr_b, i_din_b, i_be_b);
        rd_b_d = make_req(i_en_b & ~i_we_b & ~i_rst, 1'b0, i_addr_b, '0, '0);
    end

    dpr_delay_line #(.DELAY(WRITE_LATENCY_A), .T(dpr_req_t)) u_wr_a
        (.clk_i(i_clk), .rst_i(i_rst), .d_i(wr_a_d), .q_o(wr_a_q));
    dpr_delay_line #(.DELAY(WRITE_LATENCY_B), .T(dpr_req_t)) u_wr_b
        (.clk_i(i_clk), .rst_i(i_rst), .d_i(wr_b_d), .q_o(wr_b_q));
    dpr_delay_line #(.DELAY(READ_LATENCY_A), .T(dpr_req_t)) u_rd_a
        (.clk_i(i_clk), .rst_i(i_rst), .d_i(rd_a_d), .q_o(rd_a_q));
    dpr_delay_line #(.DELAY(READ_LATENCY_B), .T(dpr_req_t)) u_rd_b
        (.clk_i(i_clk), .rst_i(i_rst), .d_i(rd_b_d), .q_o(rd_b_q));

    // A write arriving at the commit stage on the reset edge is discarded too.
    logic commit_a, commit_b;
    assign commit_a = wr_a_q.en & ~i_rst & dpr_in_range(wr_a_q.addr, DEPTH);
    assign commit_b = wr_b_q.en & ~i_rst & dpr_in_range(wr_b_q.addr, DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // B is applied first so A's enabled bytes override it on the same word.
    always_ff @(posedge i_clk) begin
        if (commit_b) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (wr_b_q.be[b]) mem_q[wr_b_q.addr[IDX_W-1:0]][b*8 +: 8] <= wr_b_q.din[b*8 +: 8];
            end
        end
        if (commit_a) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (wr_a_q.be[b]) mem_q[wr_a_q.addr[IDX_W-1:0]][b*8 +: 8] <= wr_a_q.din[b*8 +: 8];
            end
        end
    end

    logic [WIDTH-1:0] dout_a_q, dout_b_q;
    logic             rvalid_a_q, rvalid_b_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dout_a_q   <= '0;
            dout_b_q   <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            rvalid_a_q <= rd_a_q.en;
            rvalid_b_q <= rd_b_q.en;
            if (rd_a_q.en) begin
                dout_a_q <= dpr_in_range(rd_a_q.addr, DEPTH) ? mem_q[rd_a_q.addr[IDX_W-1:0]] : '0;
            end
            if (rd_b_q.en) begin
                dout_b_q <= dpr_in_range(rd_b_q.addr, DEPTH) ? mem_q[rd_b_q.addr[IDX_W-1:0]] : '0;
            end
        end
    end

    assign o_dout_a   = dout_a_q;
    assign o_dout_b   = dout_b_q;
    assign o_rvalid_a = rvalid_a_q;
    assign o_rvalid_b = rvalid_b_q;

`ifdef DPR_COLLISION_EN
    // Detected on the commit edge, presented one edge later.
    logic coll_d, coll_pend_q, coll_q;
    assign coll_d = commit_a & commit_b & (wr_a_q.addr == wr_b_q.addr) &
                    (|(wr_a_q.be & wr_b_q.be));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            coll_pend_q <= 1'b0;
            coll_q      <= 1'b0;
        end else begin
            coll_pend_q <= coll_d;
            coll_q      <= coll_pend_q;
        end
    end

    assign o_collision = coll_q;
`endif

    logic unused_req_bits;
    assign unused_req_bits = ^{wr_a_q, wr_b_q, rd_a_q, rd_b_q};

endmodule

// File: tb/tb_dual_port_ram_pipelined.sv
module tb_dual_port_ram_pipelined;

    localparam int RL = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, we_a, en_b, we_b;
    logic [3:0]  addr_a, addr_b;
    logic [31:0] din_a, din_b;
    logic [3:0]  be_a, be_b;
    logic [31:0] dout_a, dout_b;
    logic        rvalid_a, rvalid_b;
`ifdef DPR_COLLISION_EN
    logic        collision;
    int          coll_cnt = 0;
`endif

    always #5 clk = ~clk;

    dual_port_ram_pipelined #(
        .WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12),
        .WRITE_LATENCY_A(4), .WRITE_LATENCY_B(4),
        .READ_LATENCY_A(RL), .READ_LATENCY_B(RL)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_en_a(en_a), .i_we_a(we_a), .i_addr_a(addr_a), .i_din_a(din_a), .i_be_a(be_a),
        .i_en_b(en_b), .i_we_b(we_b), .i_addr_b(addr_b), .i_din_b(din_b), .i_be_b(be_b),
        .o_dout_a(dout_a), .o_rvalid_a(rvalid_a),
        .o_dout_b(dout_b), .o_rvalid_b(rvalid_b)
`ifdef DPR_COLLISION_EN
       ,.o_collision(collision)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: every valid pulse must match the oldest expectation, on time.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid_a) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL rd_a unexpected rvalid at cycle %0d dout %h", cyc, dout_a);
            end else begin
                e = qa.pop_front();
                if (dout_a !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL rd_a actual %h @%0d required %h @%0d", dout_a, cyc, e.data, e.due);
                end
            end
        end
        if (rvalid_b) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL rd_b unexpected rvalid at cycle %0d dout %h", cyc, dout_b);
            end else begin
                e = qb.pop_front();
                if (dout_b !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL rd_b actual %h @%0d required %h @%0d", dout_b, cyc, e.data, e.due);
                end
            end
        end
`ifdef DPR_COLLISION_EN
        if (collision) coll_cnt++;
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        en_a = 1'b1; we_a = 1'b1; addr_a = a; din_a = d; be_a = be;
    endtask
    task automatic wr_b(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        en_b = 1'b1; we_b = 1'b1; addr_b = a; din_b = d; be_b = be;
    endtask
    task automatic rd_a(input logic [3:0] a);
        en_a = 1'b1; we_a = 1'b0; addr_a = a; din_a = '0; be_a = '0;
    endtask
    task automatic rd_b(input logic [3:0] a);
        en_b = 1'b1; we_b = 1'b0; addr_b = a; din_b = '0; be_b = '0;
    endtask

    // Sample edge, then release the request lines.
    task automatic step();
        @(posedge clk);
        #1;
        en_a = 1'b0; en_b = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Call right after step(): the read was sampled on edge 'cyc'.
    task automatic exp_a(input logic [31:0] d);
        qa.push_back('{data: d, due: cyc + RL});
    endtask
    task automatic exp_b(input logic [31:0] d);
        qb.push_back('{data: d, due: cyc + RL});
    endtask

    logic [3:0]  pl_addr [4] = '{4'd0, 4'd1, 4'd4, 4'd6};
    logic [31:0] pl_data [4] = '{32'h0F1E2D3C, 32'h4B5A6978, 32'h8796A5B4, 32'hC3D2E1F0};

    initial begin
        rst = 1'b1;
        en_a = 0; we_a = 0; addr_a = 0; din_a = 0; be_a = 0;
        en_b = 0; we_b = 0; addr_b = 0; din_b = 0; be_b = 0;
        idle(3);
        check("reset_dout_a", dout_a, 32'h0);
        check("reset_dout_b", dout_b, 32'h0);
        check("reset_rvalid_a", {31'b0, rvalid_a}, 32'h0);
        check("reset_rvalid_b", {31'b0, rvalid_b}, 32'h0);
        rst = 1'b0;
        idle(2);

        // Write A, read B four edges later: data at read edge + 5.
        wr_a(4'd3, 32'hDEADBEEF, 4'hF); step();
        idle(3);
        rd_b(4'd3); step(); exp_b(32'hDEADBEEF);

        // Byte-masked write over an existing word; preload 2 and 9 on B.
        wr_a(4'd5, 32'h11223344, 4'hF); wr_b(4'd2, 32'h00000000, 4'hF); step();
        wr_a(4'd5, 32'hAABBCCDD, 4'h5); wr_b(4'd9, 32'h00000099, 4'hF); step();
        idle(4);
        rd_a(4'd5); rd_b(4'd5); step(); exp_a(32'h11BB33DD); exp_b(32'h11BB33DD);
        idle(8);
        check("hold_dout_a", dout_a, 32'h11BB33DD);
        check("hold_rvalid_a", {31'b0, rvalid_a}, 32'h0);

        // All-zero byte enables leave the word untouched.
        wr_a(4'd5, 32'hFFFFFFFF, 4'h0); step();
        idle(4);
        rd_a(4'd5); step(); exp_a(32'h11BB33DD);

        // Same-edge commits to one address: A wins its bytes, B fills the rest.
        wr_a(4'd7, 32'h000000FF, 4'h1); wr_b(4'd7, 32'hFFFFFF00, 4'hF); step();
        wr_a(4'd8, 32'h0000AAAA, 4'h3); wr_b(4'd8, 32'h55555555, 4'hF); step();
        idle(4);
        rd_a(4'd7); rd_b(4'd8); step(); exp_a(32'hFFFFFFFF); exp_b(32'h5555AAAA);

        // Read result edge equals a commit edge on the same word: old data.
        idle(2);
        rd_a(4'd2); step(); exp_a(32'h00000000);
        wr_a(4'd2, 32'h00000055, 4'hF); step();
        rd_a(4'd2); step(); exp_a(32'h00000055);

        // Out-of-range (DEPTH = 12): write dropped, read returns 0; 11 is valid.
        wr_a(4'd13, 32'hCAFEF00D, 4'hF); wr_b(4'd11, 32'h0B0B0B0B, 4'hF); step();
        idle(4);
        rd_a(4'd13); rd_b(4'd11); step(); exp_a(32'h0); exp_b(32'h0B0B0B0B);
        rd_a(4'd15); step(); exp_a(32'h0);

        // Back-to-back writes then back-to-back reads on both ports.
        for (int i = 0; i < 4; i++) begin
            wr_a(pl_addr[i], pl_data[i], 4'hF); step();
        end
        idle(1);
        for (int i = 0; i < 4; i++) begin
            rd_a(pl_addr[i]); rd_b(pl_addr[3-i]); step();
            exp_a(pl_data[i]); exp_b(pl_data[3-i]);
        end

        // Reset in the middle of a read burst, with a write to 9 in flight.
        idle(10);
        for (int i = 0; i < 8; i++) begin
            rd_a(4'(i));
            if (i == 2) wr_b(4'd9, 32'hBAD0BAD0, 4'hF);
            rst = (i >= 3);
            step();
            if (i == 3 || i == 7) begin
                check("rst_dout_a", dout_a, 32'h0);
                check("rst_dout_b", dout_b, 32'h0);
                check("rst_rvalid_a", {31'b0, rvalid_a}, 32'h0);
                check("rst_rvalid_b", {31'b0, rvalid_b}, 32'h0);
            end
        end
        rst = 1'b0;
        idle(20);
        check("post_rst_dout_a", dout_a, 32'h0);
        rd_a(4'd9); rd_b(4'd3); step(); exp_a(32'h00000099); exp_b(32'hDEADBEEF);
        rd_a(4'd7); step(); exp_a(32'hFFFFFFFF);

        for (int k = 0; k < 40 && (qa.size() != 0 || qb.size() != 0); k++) begin
            @(posedge clk);
        end
        #2;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain pending_a %0d pending_b %0d required 0", qa.size(), qb.size());
        end
`ifdef DPR_COLLISION_EN
        check("collision_pulses", 32'(coll_cnt), 32'd2);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
